// File: rtl/fetch_branch_control.sv
// fetch_branch_control
// Control stage sitting directly in front of the program counter. It decodes
// the instruction at the current PC, resolves the conditional branch that has
// reached slot 2 of a private two-slot shadow pipeline, and drives the PC's
// increment/load controls, the pipeline flush, the halt flag and a saturating
// count of taken redirects.
//
// The shadow slots advance on every edge, in step with the PC's PC_D1/PC_D2
// delay registers:
//   s2 <= s1 (invalidated when Flush is high)
//   s1 <= {fetch_valid, Instr[15:12], Instr[7:0]}
//
// State is exposed on debug_state (IDLE=0, RUN=1, DRAIN=2, HALT=3), so
// checkers can observe the FSM directly.
module fetch_branch_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [15:0] Instr,
    input  logic        Zero_Flag,
    output logic        Enable_PC,
    output logic        Update_PC,
    output logic [7:0]  New_Address,
    output logic        Flush,
    output logic        Halted,
    output logic [7:0]  Taken_Count,
    output logic [1:0]  debug_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] opcode;
        logic [7:0] target;
    } slot_t;

    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_BEQ = 4'hD;
    localparam logic [3:0] OP_BNE = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state;
    state_t     next_state;
    slot_t      s1;
    slot_t      s2;

    logic [3:0] fetch_op;
    logic [7:0] fetch_target;
    logic       fetch_valid;
    logic       s2_taken;

    // Instr[11:8] carries nothing this stage cares about.
    logic       unused_instr_bits;

    assign fetch_op          = Instr[15:12];
    assign fetch_target      = Instr[7:0];
    assign unused_instr_bits = ^Instr[11:8];
    assign debug_state       = state;

    // A slot only redirects when it is valid: flushed or bubble slots keep
    // their opcode bits but must never be acted on.
    always_comb begin
        s2_taken = 1'b0;
        if (s2.valid) begin
            if (s2.opcode == OP_BEQ) begin
                s2_taken = Zero_Flag;
            end else if (s2.opcode == OP_BNE) begin
                s2_taken = ~Zero_Flag;
            end
        end
    end

    // Next-state and PC controls. The resolved branch in s2 outranks anything
    // at fetch (JMP or HLT), since it kills the fetch slot anyway.
    always_comb begin
        next_state  = state;
        Enable_PC   = 1'b0;
        Update_PC   = 1'b0;
        New_Address = 8'h00;
        Flush       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (s2_taken) begin
                    Update_PC   = 1'b1;
                    New_Address = s2.target;
                    Flush       = 1'b1;
                end else if (fetch_op == OP_JMP) begin
                    Update_PC   = 1'b1;
                    New_Address = fetch_target;
                end else if (fetch_op == OP_HLT) begin
                    // PC holds on the HLT while the older slot drains.
                    next_state = ST_DRAIN;
                end else begin
                    Enable_PC = 1'b1;
                end
            end
            ST_DRAIN: begin
                // The instruction that was in s1 at the HLT is now in s2; a
                // taken branch there cancels the halt.
                if (s2_taken) begin
                    Update_PC   = 1'b1;
                    New_Address = s2.target;
                    Flush       = 1'b1;
                    next_state  = ST_RUN;
                end else begin
                    next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Only a RUN-state fetch that survives the flush and is not HLT enters
    // the shadow pipeline as a real instruction.
    assign fetch_valid = (state == ST_RUN) && !Flush && (fetch_op != OP_HLT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Shadow pipeline: advances every edge, flush kills the s1 occupant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s2 <= {s1.valid & ~Flush, s1.opcode, s1.target};
            s1 <= {fetch_valid, fetch_op, fetch_target};
        end
    end

    // Halted mirrors the registered HALT state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Halted <= 1'b0;
        end else begin
            Halted <= (next_state == ST_HALT);
        end
    end

    // Every redirect counts once; the counter sticks at 8'hFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Taken_Count <= 8'h00;
        end else if (Update_PC && (Taken_Count != 8'hFF)) begin
            Taken_Count <= Taken_Count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fetch_branch_control.sv
// Bench for fetch_branch_control: a per-cycle vector table for the main
// control behaviour, then hand-written sequences for reset, PC tracking,
// counter saturation and asynchronous reset mid-run.
module tb_fetch_branch_control;

    localparam int W = 22;
    localparam logic [15:0] NOP = 16'h1000;
    localparam logic [15:0] HLT = 16'hF000;
    localparam logic [1:0]  SI = 2'd0;
    localparam logic [1:0]  SR = 2'd1;
    localparam logic [1:0]  SD = 2'd2;
    localparam logic [1:0]  SH = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] instr;
    logic        zero;
    logic        enable_pc;
    logic        update_pc;
    logic [7:0]  new_address;
    logic        flush;
    logic        halted;
    logic [7:0]  taken_count;
    logic [1:0]  debug_state;
    logic [7:0]  pc;
    logic [W-1:0] act_vec;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic         start;
        logic [15:0]  instr;
        logic         zero;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    fetch_branch_control dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (start),
        .Instr       (instr),
        .Zero_Flag   (zero),
        .Enable_PC   (enable_pc),
        .Update_PC   (update_pc),
        .New_Address (new_address),
        .Flush       (flush),
        .Halted      (halted),
        .Taken_Count (taken_count),
        .debug_state (debug_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    assign act_vec = {enable_pc, update_pc, new_address, flush, halted, taken_count, debug_state};

    // Program counter model driven by the DUT's controls.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= 8'h00;
        end else if (update_pc) begin
            pc <= new_address;
        end else if (enable_pc) begin
            pc <= pc + 8'd1;
        end
    end

    function automatic logic [W-1:0] pk(input logic en, input logic upd, input logic [7:0] addr,
                                        input logic fl, input logic h, input logic [7:0] cnt,
                                        input logic [1:0] st);
        return {en, upd, addr, fl, h, cnt, st};
    endfunction

    function automatic vec_t v(input logic s, input logic [15:0] i, input logic z,
                               input logic en, input logic upd, input logic [7:0] addr,
                               input logic fl, input logic h, input logic [7:0] cnt,
                               input logic [1:0] st);
        vec_t r;
        r.start = s;
        r.instr = i;
        r.zero  = z;
        r.exp   = pk(en, upd, addr, fl, h, cnt, st);
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {en,upd,addr,flush,halted,count,state}=%h, expected %h", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // driver: apply one cycle of inputs, queue the expectation, compare
    // before the next rising edge
    task automatic drive(input logic s, input logic [15:0] i, input logic z,
                         input logic [W-1:0] e, input string name);
        logic [W-1:0] x;
        @(negedge clk);
        start = s;
        instr = i;
        zero  = z;
        exp_q.push_back(e);
        #2;
        x = exp_q.pop_front();
        check(name, act_vec, x);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        instr = NOP;
        zero  = 1'b0;

        //     start instr     z  en upd addr  fl h cnt st
        vecs.push_back(v(0, NOP,     0, 0, 0, 8'h00, 0, 0, 0, SI)); // reset state
        vecs.push_back(v(1, NOP,     0, 0, 0, 8'h00, 0, 0, 0, SI)); // start
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 0, SR));
        vecs.push_back(v(1, NOP,     0, 1, 0, 8'h00, 0, 0, 0, SR)); // start ignored in RUN
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 0, SR));
        vecs.push_back(v(0, 16'hC040,0, 0, 1, 8'h40, 0, 0, 0, SR)); // JMP
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 1, SR));
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 1, SR)); // JMP in s2: no effect
        vecs.push_back(v(0, 16'hD020,0, 1, 0, 8'h00, 0, 0, 1, SR)); // BEQ fetched
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 1, SR));
        vecs.push_back(v(0, 16'hC077,1, 0, 1, 8'h20, 1, 0, 1, SR)); // BEQ taken beats JMP
        vecs.push_back(v(0, NOP,     1, 1, 0, 8'h00, 0, 0, 2, SR)); // flushed s1 silent
        vecs.push_back(v(0, 16'hD020,0, 1, 0, 8'h00, 0, 0, 2, SR));
        vecs.push_back(v(0, 16'hD030,0, 1, 0, 8'h00, 0, 0, 2, SR));
        vecs.push_back(v(0, NOP,     1, 0, 1, 8'h20, 1, 0, 2, SR)); // first BEQ taken
        vecs.push_back(v(0, NOP,     1, 1, 0, 8'h00, 0, 0, 3, SR)); // flushed BEQ ignored
        vecs.push_back(v(0, 16'hE050,0, 1, 0, 8'h00, 0, 0, 3, SR)); // BNE
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 3, SR));
        vecs.push_back(v(0, NOP,     1, 1, 0, 8'h00, 0, 0, 3, SR)); // BNE not taken
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 3, SR));
        vecs.push_back(v(0, 16'hE060,1, 1, 0, 8'h00, 0, 0, 3, SR));
        vecs.push_back(v(0, NOP,     1, 1, 0, 8'h00, 0, 0, 3, SR));
        vecs.push_back(v(0, NOP,     0, 0, 1, 8'h60, 1, 0, 3, SR)); // BNE taken
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 4, SR));
        vecs.push_back(v(0, 16'hD090,0, 1, 0, 8'h00, 0, 0, 4, SR));
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 4, SR));
        vecs.push_back(v(0, HLT,     1, 0, 1, 8'h90, 1, 0, 4, SR)); // branch beats HLT
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 5, SR)); // still RUN
        vecs.push_back(v(0, 16'hD088,0, 1, 0, 8'h00, 0, 0, 5, SR));
        vecs.push_back(v(0, HLT,     0, 0, 0, 8'h00, 0, 0, 5, SR)); // HLT, BEQ in s1
        vecs.push_back(v(0, HLT,     1, 0, 1, 8'h88, 1, 0, 5, SD)); // DRAIN redirect
        vecs.push_back(v(0, NOP,     0, 1, 0, 8'h00, 0, 0, 6, SR)); // back in RUN
        vecs.push_back(v(0, HLT,     0, 0, 0, 8'h00, 0, 0, 6, SR)); // HLT, no branch
        vecs.push_back(v(0, HLT,     1, 0, 0, 8'h00, 0, 0, 6, SD)); // DRAIN, no redirect
        vecs.push_back(v(1, 16'hC040,1, 0, 0, 8'h00, 0, 1, 6, SH)); // HALT, start ignored
        vecs.push_back(v(0, NOP,     0, 0, 0, 8'h00, 0, 1, 6, SH));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].start, vecs[k].instr, vecs[k].zero, vecs[k].exp, $sformatf("vec%0d", k));
        end

        // reset while halted: everything back to zero immediately
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_from_halt", act_vec, pk(0, 0, 8'h00, 0, 0, 8'h00, SI));
        @(negedge clk);
        reset = 1'b0;

        // PC counts 0,1,2,3 then JMP 8'h40 at PC=3
        drive(1, NOP, 0, pk(0, 0, 8'h00, 0, 0, 8'h00, SI), "pc_start");
        check8("pc_idle", pc, 8'h00);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                drive(0, 16'hC040, 0, pk(0, 1, 8'h40, 0, 0, 8'h00, SR), "pc_jmp");
            end else begin
                drive(0, NOP, 0, pk(1, 0, 8'h00, 0, 0, 8'h00, SR), $sformatf("pc_run%0d", k));
            end
            check8($sformatf("pc_value%0d", k), pc, k[7:0]);
        end

        // keep fetching JMP 8'h40: the count climbs to 8'hFF and sticks
        for (int j = 0; j < 259; j++) begin
            drive(0, 16'hC040, 0, pk(0, 1, 8'h40, 0, 0, (j >= 254) ? 8'hFF : 8'(j + 1), SR),
                  $sformatf("sat%0d", j));
            if (j == 0) begin
                check8("pc_after_jmp", pc, 8'h40);
            end
        end

        // asynchronous reset in the middle of a redirect
        @(negedge clk);
        instr = 16'hC040;
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_now", act_vec, pk(0, 0, 8'h00, 0, 0, 8'h00, SI));
        @(posedge clk);
        #1;
        check("async_reset_held", act_vec, pk(0, 0, 8'h00, 0, 0, 8'h00, SI));
        check8("pc_reset", pc, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 16'hC040, 0, pk(0, 0, 8'h00, 0, 0, 8'h00, SI), "idle_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
